rf_bank_read_scheduler: RTL and testbench

Sits between the register allocation unit (RAU) and the four register-file SRAM banks. It is the producer side of the RF→Operand Collector return path.
- Accepts up to two source-operand read requests per cycle, tagged with OC entry number and src1/src2 id.
- Maps each request to a bank and queues it per bank.
- Issues at most one read per bank per cycle; bank writes take priority over reads.
- Returns data with aligned RF_Dout_Valid / EntryNum / SrcNum tags to the Operand Collector.

---
 rtl/rf_bank_read_scheduler_pkg.sv | 31 +++
 rtl/rf_bank_read_scheduler_fifo.sv | 60 ++++++
 rtl/rf_bank_read_scheduler.sv | 124 ++++++++++++
 tb/tb_rf_bank_read_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_bank_read_scheduler_pkg.sv
// rtl/rf_bank_read_scheduler_pkg.sv - shared types and bank/row mapping for the RF bank read scheduler
package rf_bank_read_scheduler_pkg;

  localparam int NUM_BANKS  = 4;
  localparam int OC_ENTRIES = 4;
  localparam int ROW_BITS   = 5;
  localparam int ENTRY_W    = $clog2(OC_ENTRIES);

  typedef logic [1:0] bank_idx_t;

  typedef struct packed {
    logic [ROW_BITS-1:0] row;
    logic [ENTRY_W-1:0]  entry;
    logic                srcnum;
  } rf_req_tag_t;

  typedef struct packed {
    logic [ENTRY_W-1:0] entry;
    logic               srcnum;
  } rf_ret_tag_t;

  // Warp offset spreads the same register index of different warps over banks.
  function automatic bank_idx_t bank_of(input logic [1:0] warp_lo, input logic [1:0] phys_lo);
    return bank_idx_t'(phys_lo + warp_lo);
  endfunction

  function automatic logic [ROW_BITS-1:0] row_of(input logic [2:0] warp, input logic [1:0] phys_hi);
    return {warp, phys_hi};
  endfunction

endpackage

// File: rtl/rf_bank_read_scheduler_fifo.sv
// rtl/rf_bank_read_scheduler_fifo.sv - dual-push ordered, single-pop request FIFO with occupancy
module rf_bank_req_fifo
  import rf_bank_read_scheduler_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push0_i,
  input  rf_req_tag_t            push0_data_i,
  input  logic                   push1_i,
  input  rf_req_tag_t            push1_data_i,
  input  logic                   pop_i,
  output rf_req_tag_t            head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  rf_req_tag_t mem_q [DEPTH];
  ptr_t        wptr_q, wptr_d;
  ptr_t        rptr_q, rptr_d;
  ptr_t        free_slots;
  logic        full;
  logic        acc0, acc1, pop_ok;
  logic [AW-1:0] slot1;

  always_comb begin
    full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    empty_o    = (wptr_q == rptr_q);
    count_o    = wptr_q - rptr_q;
    free_slots = ptr_t'(DEPTH) - count_o;
    // Capacity is judged on the occupancy before this cycle's pop.
    acc0       = push0_i && !full;
    acc1       = push1_i && (free_slots > ptr_t'(acc0));
    pop_ok     = pop_i && !empty_o;
    slot1      = acc0 ? (wptr_q[AW-1:0] + 1'b1) : wptr_q[AW-1:0];
    wptr_d     = wptr_q + ptr_t'(acc0) + ptr_t'(acc1);
    rptr_d     = rptr_q + ptr_t'(pop_ok);
    head_o     = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc0) mem_q[wptr_q[AW-1:0]] <= push0_data_i;
    if (acc1) mem_q[slot1] <= push1_data_i;
  end

endmodule

// File: rtl/rf_bank_read_scheduler.sv
// rtl/rf_bank_read_scheduler.sv - maps RAU operand reads onto four RF banks and returns tagged data to the OC
module rf_bank_read_scheduler
  import rf_bank_read_scheduler_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 256,
  parameter int ROW_W  = ROW_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   RAU_Req_Valid,
  input  logic [2:0]             RAU_WarpID,
  input  logic [1:0]             RAU_EntryNum_OC,
  input  logic [4:0]             RAU_Src1_PhyRegAddr,
  input  logic [4:0]             RAU_Src2_PhyRegAddr,
  output logic                   RFS_Full,
  input  logic [3:0]             Bank_Wr_Busy,
  output logic [3:0]             Bank_Rd_En,
  output logic [4*ROW_W-1:0]     Bank_Rd_Addr,
  input  logic [DATA_W-1:0]      Bank_Rd_Data0,
  input  logic [DATA_W-1:0]      Bank_Rd_Data1,
  input  logic [DATA_W-1:0]      Bank_Rd_Data2,
  input  logic [DATA_W-1:0]      Bank_Rd_Data3,
  output logic [DATA_W-1:0]      RF_Out_Bank0,
  output logic [DATA_W-1:0]      RF_Out_Bank1,
  output logic [DATA_W-1:0]      RF_Out_Bank2,
  output logic [DATA_W-1:0]      RF_Out_Bank3,
  output logic [1:0]             RF_Bank0_EntryNum_OC,
  output logic [1:0]             RF_Bank1_EntryNum_OC,
  output logic [1:0]             RF_Bank2_EntryNum_OC,
  output logic [1:0]             RF_Bank3_EntryNum_OC,
  output logic [3:0]             RF_Dout_Valid,
  output logic [3:0]             RF_SrcNum_OC
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  typedef logic [CNT_W-1:0] cnt_t;

  logic                 src1_req, src2_req;
  bank_idx_t            src1_bank, src2_bank;
  rf_req_tag_t          src1_tag, src2_tag;
  logic [NUM_BANKS-1:0] push0, push1, fifo_empty, rd_en;
  rf_req_tag_t          head [NUM_BANKS];
  cnt_t                 fifo_count [NUM_BANKS];
  rf_ret_tag_t          ret_tag_q [NUM_BANKS];
  rf_ret_tag_t          ret_tag_d [NUM_BANKS];
  logic [NUM_BANKS-1:0] dout_valid_q, dout_valid_d;

  always_comb begin
    src1_req  = RAU_Req_Valid && RAU_Src1_PhyRegAddr[4];
    src2_req  = RAU_Req_Valid && RAU_Src2_PhyRegAddr[4];
    src1_bank = bank_of(RAU_WarpID[1:0], RAU_Src1_PhyRegAddr[1:0]);
    src2_bank = bank_of(RAU_WarpID[1:0], RAU_Src2_PhyRegAddr[1:0]);
    src1_tag  = '{row: row_of(RAU_WarpID, RAU_Src1_PhyRegAddr[3:2]), entry: RAU_EntryNum_OC, srcnum: 1'b0};
    src2_tag  = '{row: row_of(RAU_WarpID, RAU_Src2_PhyRegAddr[3:2]), entry: RAU_EntryNum_OC, srcnum: 1'b1};
    push0     = '0;
    push1     = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      push0[b] = src1_req && (src1_bank == bank_idx_t'(b));
      push1[b] = src2_req && (src2_bank == bank_idx_t'(b));
    end
  end

  // src1 rides the first push port so a same-bank pair pops src1 first.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    rf_bank_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push0_i      (push0[b]),
      .push0_data_i (src1_tag),
      .push1_i      (push1[b]),
      .push1_data_i (src2_tag),
      .pop_i        (rd_en[b]),
      .head_o       (head[b]),
      .empty_o      (fifo_empty[b]),
      .count_o      (fifo_count[b])
    );
  end

  // A writeback on the bank wins; the queued read simply waits at the head.
  always_comb begin
    RFS_Full     = 1'b0;
    rd_en        = '0;
    Bank_Rd_Addr = '0;
    dout_valid_d = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd_en[b]        = !fifo_empty[b] && !Bank_Wr_Busy[b];
      dout_valid_d[b] = rd_en[b];
      ret_tag_d[b]    = ret_tag_q[b];
      if (rd_en[b]) begin
        Bank_Rd_Addr[b*ROW_W +: ROW_W] = head[b].row;
        ret_tag_d[b] = '{entry: head[b].entry, srcnum: head[b].srcnum};
      end
      if (fifo_count[b] > cnt_t'(DEPTH - 2)) RFS_Full = 1'b1;
    end
    Bank_Rd_En = rd_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) ret_tag_q[b] <= '0;
    end else begin
      dout_valid_q <= dout_valid_d;
      for (int b = 0; b < NUM_BANKS; b++) ret_tag_q[b] <= ret_tag_d[b];
    end
  end

  always_comb begin
    RF_Dout_Valid        = dout_valid_q;
    RF_Bank0_EntryNum_OC = ret_tag_q[0].entry;
    RF_Bank1_EntryNum_OC = ret_tag_q[1].entry;
    RF_Bank2_EntryNum_OC = ret_tag_q[2].entry;
    RF_Bank3_EntryNum_OC = ret_tag_q[3].entry;
    RF_SrcNum_OC         = {ret_tag_q[3].srcnum, ret_tag_q[2].srcnum, ret_tag_q[1].srcnum, ret_tag_q[0].srcnum};
    RF_Out_Bank0         = Bank_Rd_Data0;
    RF_Out_Bank1         = Bank_Rd_Data1;
    RF_Out_Bank2         = Bank_Rd_Data2;
    RF_Out_Bank3         = Bank_Rd_Data3;
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(RAU_Req_Valid && RFS_Full));

endmodule

// File: tb/tb_rf_bank_read_scheduler.sv
// tb/tb_rf_bank_read_scheduler.sv - self-checking bench with a queue-based reference model
module tb_rf_bank_read_scheduler;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 256;

  typedef struct packed {
    logic [4:0] row;
    logic [1:0] entry;
    logic       src;
  } mtag_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid = 1'b0;
  logic [2:0]        warp = '0;
  logic [1:0]        entry = '0;
  logic [4:0]        s1 = '0, s2 = '0;
  logic [3:0]        busy = '0;
  logic              full;
  logic [3:0]        rd_en, dv, srcn;
  logic [19:0]       rd_addr;
  logic [DATA_W-1:0] rdat [4];
  logic [DATA_W-1:0] rout [4];
  logic [1:0]        ent [4];

  mtag_t      mq [4][$];
  mtag_t      mtag [4];
  logic [3:0] mdv;
  logic [3:0] e_rd_en;
  logic [4:0] e_addr [4];
  logic       e_full;
  int         errors = 0;
  int         checks = 0;

  rf_bank_read_scheduler #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ROW_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .RAU_Req_Valid(req_valid), .RAU_WarpID(warp), .RAU_EntryNum_OC(entry),
    .RAU_Src1_PhyRegAddr(s1), .RAU_Src2_PhyRegAddr(s2),
    .RFS_Full(full), .Bank_Wr_Busy(busy), .Bank_Rd_En(rd_en), .Bank_Rd_Addr(rd_addr),
    .Bank_Rd_Data0(rdat[0]), .Bank_Rd_Data1(rdat[1]), .Bank_Rd_Data2(rdat[2]), .Bank_Rd_Data3(rdat[3]),
    .RF_Out_Bank0(rout[0]), .RF_Out_Bank1(rout[1]), .RF_Out_Bank2(rout[2]), .RF_Out_Bank3(rout[3]),
    .RF_Bank0_EntryNum_OC(ent[0]), .RF_Bank1_EntryNum_OC(ent[1]),
    .RF_Bank2_EntryNum_OC(ent[2]), .RF_Bank3_EntryNum_OC(ent[3]),
    .RF_Dout_Valid(dv), .RF_SrcNum_OC(srcn)
  );

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      mq[b].delete();
      mtag[b] = '0;
    end
    mdv = '0;
  endtask

  function automatic void enq(input logic [2:0] w, input logic [1:0] e, input logic [4:0] a, input logic sn);
    int    b;
    mtag_t t;
    b       = (int'(a[1:0]) + int'(w[1:0])) % 4;
    t.row   = {w, a[3:2]};
    t.entry = e;
    t.src   = sn;
    if (mq[b].size() < DEPTH) mq[b].push_back(t);
  endfunction

  // Called just after a falling edge: drive one cycle of inputs, then form expectations.
  task automatic cyc(input logic v, input logic [2:0] w, input logic [1:0] e,
                     input logic [4:0] a1, input logic [4:0] a2, input logic [3:0] bz);
    req_valid = v; warp = w; entry = e; s1 = a1; s2 = a2; busy = bz;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++) rdat[b][i*32 +: 32] = $urandom();
    #1;
    e_full = 1'b0;
    for (int b = 0; b < 4; b++) begin
      e_rd_en[b] = (mq[b].size() != 0) && !bz[b];
      e_addr[b]  = e_rd_en[b] ? mq[b][0].row : 5'd0;
      if (mq[b].size() > DEPTH - 2) e_full = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (req_valid) begin
      if (s1[4]) enq(warp, entry, s1, 1'b0);
      if (s2[4]) enq(warp, entry, s2, 1'b1);
    end
    for (int b = 0; b < 4; b++) begin
      mdv[b] = e_rd_en[b];
      if (e_rd_en[b]) mtag[b] = mq[b].pop_front();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 4'd0);
    checks++; if (dv !== 4'b0) begin errors++; $display("FAIL reset_dv: got %b want 0000", dv); end
    checks++; if (rd_en !== 4'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0000", rd_en); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (srcn !== 4'b0) begin errors++; $display("FAIL reset_srcnum: got %b want 0000", srcn); end
    checks++; if ({ent[3], ent[2], ent[1], ent[0]} !== 8'h00) begin
      errors++; $display("FAIL reset_entry: got %h want 00", {ent[3], ent[2], ent[1], ent[0]});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    cyc(1'b1, 3'd1, 2'd2, 5'b1_0010, 5'b0_0000, 4'd0); tick();
    cyc(1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 4'd0);
    checks++; if (rd_en !== 4'b1000) begin errors++; $display("FAIL single_rd_en: got %b want 1000", rd_en); end
    checks++; if (rd_addr[15 +: 5] !== 5'b00100) begin errors++; $display("FAIL single_addr: got %b want 00100", rd_addr[15 +: 5]); end
    tick();
    cyc(1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 4'd0);
    checks++; if (dv !== 4'b1000) begin errors++; $display("FAIL single_dv: got %b want 1000", dv); end
    checks++; if (ent[3] !== 2'd2) begin errors++; $display("FAIL single_entry: got %0d want 2", ent[3]); end
    checks++; if (srcn[3] !== 1'b0) begin errors++; $display("FAIL single_srcnum: got %b want 0", srcn[3]); end
    tick();
    cyc(1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 4'd0);
    checks++; if (dv !== 4'b0000) begin errors++; $display("FAIL single_dv_after: got %b want 0000", dv); end
    tick();
  endtask

  task automatic test_same_bank();
    cyc(1'b1, 3'd0, 2'd1, 5'b1_0001, 5'b1_0101, 4'd0); tick();
    cyc(1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 4'd0);
    checks++; if (rd_en !== 4'b0010 || rd_addr[5 +: 5] !== 5'd0) begin
      errors++; $display("FAIL pair_issue1: got en=%b addr=%0d want en=0010 addr=0", rd_en, rd_addr[5 +: 5]);
    end
    tick();
    cyc(1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 4'd0);
    checks++; if (rd_en !== 4'b0010 || rd_addr[5 +: 5] !== 5'd1) begin
      errors++; $display("FAIL pair_issue2: got en=%b addr=%0d want en=0010 addr=1", rd_en, rd_addr[5 +: 5]);
    end
    checks++; if (dv !== 4'b0010 || srcn[1] !== 1'b0) begin
      errors++; $display("FAIL pair_ret1: got dv=%b src=%b want dv=0010 src=0", dv, srcn[1]);
    end
    tick();
    cyc(1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 4'd0);
    checks++; if (dv !== 4'b0010 || srcn[1] !== 1'b1 || ent[1] !== 2'd1) begin
      errors++; $display("FAIL pair_ret2: got dv=%b src=%b ent=%0d want dv=0010 src=1 ent=1", dv, srcn[1], ent[1]);
    end
    checks++; if (rd_en !== 4'b0000) begin errors++; $display("FAIL pair_idle: got %b want 0000", rd_en); end
    tick();
  endtask

  task automatic test_write_priority();
    cyc(1'b1, 3'd0, 2'd3, 5'b1_0000, 5'b0_0000, 4'd0); tick();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 4'b0001);
      checks++; if (rd_en[0] !== 1'b0) begin errors++; $display("FAIL wrprio_blocked cyc %0d: got %b want 0", i, rd_en[0]); end
      tick();
    end
    cyc(1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 4'd0);
    checks++; if (rd_en[0] !== 1'b1 || rd_addr[4:0] !== 5'd0) begin
      errors++; $display("FAIL wrprio_issue: got en=%b addr=%0d want en=1 addr=0", rd_en[0], rd_addr[4:0]);
    end
    tick();
    cyc(1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 4'd0);
    checks++; if (dv[0] !== 1'b1 || ent[0] !== 2'd3 || srcn[0] !== 1'b0) begin
      errors++; $display("FAIL wrprio_ret: got dv=%b ent=%0d src=%b want dv=1 ent=3 src=0", dv[0], ent[0], srcn[0]);
    end
    tick();
  endtask

  task automatic test_full();
    int         j;
    logic [4:0] exp_row;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 3'(k), 2'(k), {1'b1, 2'(k), 2'(2 - k)}, {1'b1, 2'(3 - k), 2'(2 - k)}, 4'b0100);
      checks++; if (full !== 1'b0 || rd_en[2] !== 1'b0) begin
        errors++; $display("FAIL full_fill pair %0d: got full=%b en=%b want full=0 en=0", k, full, rd_en[2]);
      end
      tick();
    end
    cyc(1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 4'b0100);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_at_8: got %b want 1", full); end
    tick();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 4'd0);
      checks++; if (full !== (i < 2)) begin errors++; $display("FAIL full_drain cyc %0d: got %b want %b", i, full, (i < 2)); end
      checks++; if (rd_en[2] !== (i < 8)) begin errors++; $display("FAIL full_rd_en cyc %0d: got %b want %b", i, rd_en[2], (i < 8)); end
      if (i < 8) begin
        j = i;
        exp_row = (j % 2 == 0) ? {3'(j / 2), 2'(j / 2)} : {3'(j / 2), 2'(3 - j / 2)};
        checks++; if (rd_addr[10 +: 5] !== exp_row) begin
          errors++; $display("FAIL full_addr cyc %0d: got %b want %b", i, rd_addr[10 +: 5], exp_row);
        end
      end
      if (i >= 1 && i <= 8) begin
        j = i - 1;
        checks++; if (dv[2] !== 1'b1 || ent[2] !== 2'(j / 2) || srcn[2] !== 1'(j % 2)) begin
          errors++; $display("FAIL full_ret %0d: got dv=%b ent=%0d src=%b want dv=1 ent=%0d src=%0d", j, dv[2], ent[2], srcn[2], j / 2, j % 2);
        end
      end
      tick();
    end
  endtask

  task automatic test_special();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 3'($urandom), 2'($urandom), {1'b0, 4'($urandom)}, {1'b0, 4'($urandom)}, 4'd0);
      checks++; if (rd_en !== 4'b0 || dv !== 4'b0) begin
        errors++; $display("FAIL special cyc %0d: got en=%b dv=%b want 0000 0000", i, rd_en, dv);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 3'd0, 2'd1, 5'b1_0000, 5'b1_0100, 4'b1000); tick();
    cyc(1'b1, 3'd3, 2'd2, 5'b1_0000, 5'b1_1100, 4'b1000); tick();
    cyc(1'b1, 3'd3, 2'd3, 5'b1_0100, 5'b0_0000, 4'b1000); tick();
    cyc(1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 4'b1000);
    checks++; if (dv !== 4'b0001) begin errors++; $display("FAIL rstmid_pre_dv: got %b want 0001", dv); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dv !== 4'b0 || rd_en !== 4'b0 || full !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got dv=%b en=%b full=%b want 0000 0000 0", dv, rd_en, full);
    end
    checks++; if (srcn !== 4'b0 || {ent[3], ent[2], ent[1], ent[0]} !== 8'h00) begin
      errors++; $display("FAIL rstmid_tags: got src=%b ent=%h want 0000 00", srcn, {ent[3], ent[2], ent[1], ent[0]});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 3'd0, 2'd0, 5'd0, 5'd0, 4'd0);
      checks++; if (rd_en !== 4'b0 || dv !== 4'b0 || full !== 1'b0) begin
        errors++; $display("FAIL rstmid_stale cyc %0d: got en=%b dv=%b full=%b want 0000 0000 0", i, rd_en, dv, full);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic       v;
    logic [4:0] a1, a2;
    logic [3:0] bz;
    for (int n = 0; n < 340; n++) begin
      v = 1'b1;
      for (int b = 0; b < 4; b++) if (mq[b].size() > DEPTH - 2) v = 1'b0;
      v  = v && (n < 300) && ($urandom_range(0, 3) != 0);
      a1 = 5'($urandom); a1[4] = ($urandom_range(0, 9) < 7);
      a2 = 5'($urandom); a2[4] = ($urandom_range(0, 9) < 7);
      bz = (n < 300) ? (4'($urandom) & 4'($urandom)) : 4'd0;
      cyc(v, 3'($urandom), 2'($urandom), a1, a2, bz);
      checks++; if (rd_en !== e_rd_en) begin errors++; $display("FAIL rnd_rd_en cyc %0d: got %b want %b", n, rd_en, e_rd_en); end
      checks++; if (full !== e_full) begin errors++; $display("FAIL rnd_full cyc %0d: got %b want %b", n, full, e_full); end
      checks++; if (dv !== mdv) begin errors++; $display("FAIL rnd_dv cyc %0d: got %b want %b", n, dv, mdv); end
      for (int b = 0; b < 4; b++) begin
        if (e_rd_en[b]) begin
          checks++; if (rd_addr[b*5 +: 5] !== e_addr[b]) begin
            errors++; $display("FAIL rnd_addr cyc %0d bank %0d: got %b want %b", n, b, rd_addr[b*5 +: 5], e_addr[b]);
          end
        end
        if (mdv[b]) begin
          checks++; if (ent[b] !== mtag[b].entry || srcn[b] !== mtag[b].src) begin
            errors++; $display("FAIL rnd_tag cyc %0d bank %0d: got ent=%0d src=%b want ent=%0d src=%b", n, b, ent[b], srcn[b], mtag[b].entry, mtag[b].src);
          end
        end
        checks++; if (rout[b] !== rdat[b]) begin errors++; $display("FAIL rnd_data cyc %0d bank %0d: got %h want %h", n, b, rout[b][31:0], rdat[b][31:0]); end
      end
      tick();
    end
  endtask

  initial begin
    for (int b = 0; b < 4; b++) rdat[b] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_single_read();
    test_same_bank();
    test_write_priority();
    test_full();
    test_special();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
